xalu_ctrl: RTL and testbench

XALU_CTRL -- requirements
Module: xalu_ctrl

---
 rtl/xalu_ctrl_pkg.sv | 36 +++
 rtl/xalu_arith.sv | 49 ++++
 rtl/xalu_ctrl.sv | 103 ++++++++++
 tb/tb_xalu_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/xalu_ctrl_pkg.sv
// Shared XALU definitions: operand width, op encodings, default latencies and
// FSM state type. Imported by the decoder, hazard unit and the XALU itself.
package xalu_ctrl_pkg;

  localparam int unsigned XALU_W           = 32;
  localparam int unsigned XALU_MULT_CYCLES = 5;
  localparam int unsigned XALU_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } xalu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } xalu_state_e;

  // Ops 0-3 are the multi-cycle mult/div group.
  function automatic logic is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

  // Within the mult/div group, bit 1 selects divide.
  function automatic logic is_div(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/xalu_arith.sv
// Combinational 64-bit multiply/divide datapath for the XALU.
// Ports: a, b  - latched operands
//        op    - latched op (only MULT/MULTU/DIV/DIVU meaningful)
//        hi_res, lo_res - result halves to be written into HI/LO
//        div0  - divide op with zero divisor; HI/LO must not be written
module xalu_arith
  import xalu_ctrl_pkg::*;
(
  input  logic [XALU_W-1:0] a,
  input  logic [XALU_W-1:0] b,
  input  xalu_op_e          op,
  output logic [XALU_W-1:0] hi_res,
  output logic [XALU_W-1:0] lo_res,
  output logic              div0
);

  logic [2*XALU_W-1:0]        prod_s;
  logic [2*XALU_W-1:0]        prod_u;
  logic [XALU_W-1:0]          divisor;
  logic signed [XALU_W-1:0]   quo_s;
  logic signed [XALU_W-1:0]   rem_s;
  logic [XALU_W-1:0]          quo_u;
  logic [XALU_W-1:0]          rem_u;

  // Sign-extending to 64 bits makes the truncated 64-bit product the signed product.
  assign prod_s = {{XALU_W{a[XALU_W-1]}}, a} * {{XALU_W{b[XALU_W-1]}}, b};
  assign prod_u = {{XALU_W{1'b0}}, a} * {{XALU_W{1'b0}}, b};

  // Substitute 1 for a zero divisor so the dividers never see x; result is discarded.
  assign divisor = (b == '0) ? XALU_W'(1) : b;
  assign quo_s   = $signed(a) / $signed(divisor);
  assign rem_s   = $signed(a) % $signed(divisor);
  assign quo_u   = a / divisor;
  assign rem_u   = a % divisor;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    div0   = 1'b0;
    case (op)
      OP_MULT:  begin hi_res = prod_s[2*XALU_W-1:XALU_W]; lo_res = prod_s[XALU_W-1:0]; end
      OP_MULTU: begin hi_res = prod_u[2*XALU_W-1:XALU_W]; lo_res = prod_u[XALU_W-1:0]; end
      OP_DIV:   begin hi_res = rem_s; lo_res = quo_s; div0 = (b == '0); end
      OP_DIVU:  begin hi_res = rem_u; lo_res = quo_u; div0 = (b == '0); end
      default:  ;
    endcase
  end

endmodule

// File: rtl/xalu_ctrl.sv
// XALU control: launch acceptance, fixed-latency busy counter, HI/LO registers.
// Ports: clk, reset (async active-low)
//        start, op, a, b, flush - E-stage launch interface
//        d_use_xalu             - D-stage instruction touches HI/LO or mult/div
//        busy  - registered, operation in flight
//        stall - combinational D-stage stall request
//        hi, lo - architectural HI/LO
module xalu_ctrl
  import xalu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = XALU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = XALU_DIV_CYCLES
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XALU_W-1:0] a,
  input  logic [XALU_W-1:0] b,
  input  logic              flush,
  input  logic              d_use_xalu,
  output logic              busy,
  output logic              stall,
  output logic [XALU_W-1:0] hi,
  output logic [XALU_W-1:0] lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  xalu_state_e        state;
  logic [CNT_W-1:0]   cnt;
  xalu_op_e           op_q;
  logic [XALU_W-1:0]  a_q;
  logic [XALU_W-1:0]  b_q;
  logic [XALU_W-1:0]  hi_res;
  logic [XALU_W-1:0]  lo_res;
  logic               div0;

  xalu_arith u_arith (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .div0   (div0)
  );

  // FSM, latency counter and HI/LO update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (is_muldiv(op)) begin
              op_q <= xalu_op_e'(op);
              a_q  <= a;
              b_q  <= b;
              busy <= 1'b1;
              if (is_div(op)) begin
                cnt   <= CNT_W'(DIV_CYCLES);
                state <= ST_DIV;
              end else begin
                cnt   <= CNT_W'(MULT_CYCLES);
                state <= ST_MUL;
              end
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // Start and flush are ignored here: an accepted op always completes.
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!div0) begin
              hi <= hi_res;
              lo <= lo_res;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall covers the launch cycle as well as every busy cycle; drops as busy falls.
  assign stall = d_use_xalu & (busy | (start & ~flush & is_muldiv(op)));

endmodule

// File: tb/tb_xalu_ctrl.sv
// Self-checking bench for xalu_ctrl: scoreboard of expected HI/LO/latency per launch.
module tb_xalu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        d_use_xalu;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];

  xalu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .flush      (flush),
    .d_use_xalu (d_use_xalu),
    .busy       (busy),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference results; the caller avoids the -2^31 / -1 overflow case.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'd0: return 64'(sx * sy);
      3'd1: return 64'(ux * uy);
      3'd2: if (y == 0) return cur; else return {32'(sx % sy), 32'(sx / sy)};
      3'd3: if (y == 0) return cur; else return {32'(ux % uy), 32'(ux / uy)};
      default: return cur;
    endcase
  endfunction

  // Launch from the current time point; accept happens at the next rising edge.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input logic dx, input logic flush_mid);
    exp_t e;
    exp_t g;
    int   n;
    start = 1'b1; op = o; a = x; b = y; flush = 1'b0; d_use_xalu = dx;
    #1;
    check({tag, "_launch_stall"}, 32'(stall), 32'(dx));
    e.tag = tag; e.hi = eh; e.lo = el; e.cycles = (o[1]) ? 10 : 5;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (dx) check({tag, "_busy_stall"}, 32'(stall), 32'd1);
      flush = flush_mid && (n == 2 || n == 3);
      @(posedge clk); #1;
    end
    flush = 1'b0;
    g = sb.pop_front();
    check({g.tag, "_busy_cycles"}, 32'(n), 32'(g.cycles));
    check({g.tag, "_stall_release"}, 32'(stall), 32'd0);
    check({g.tag, "_hi"}, hi, g.hi);
    check({g.tag, "_lo"}, lo, g.lo);
    m_hi = g.hi; m_lo = g.lo;
    d_use_xalu = 1'b0;
  endtask

  task automatic mt_op(input string tag, input logic [2:0] o, input logic [31:0] x);
    start = 1'b1; op = o; a = x; flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    if (o == 3'd4) m_hi = x;
    if (o == 3'd5) m_lo = x;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  always @(posedge clk) begin
    if (reset && busy && start)
      $error("start asserted while busy");
  end

  initial begin
    logic [63:0] r;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; d_use_xalu = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // First launch is presented together with reset release.
    @(negedge clk);
    reset = 1'b1;
    do_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0);
    do_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);

    mt_op("mthi", 3'd4, 32'h0000_1234);
    do_op("div0", 3'd2, 32'd55, 32'd0, 32'h0000_1234, m_lo, 1'b0, 1'b0);
    mt_op("mtlo", 3'd5, 32'hCAFE_F00D);
    mt_op("nop6", 3'd6, 32'hDEAD_BEEF);
    mt_op("nop7", 3'd7, 32'hDEAD_BEEF);

    // Flushed launch: nothing happens, no stall.
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; flush = 1'b1; d_use_xalu = 1'b1;
    #1;
    check("flush_launch_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; d_use_xalu = 1'b0;
    check("flush_launch_busy", 32'(busy), 32'd0);
    check("flush_launch_hi", hi, m_hi);
    check("flush_launch_lo", lo, m_lo);

    // Flush while busy has no effect.
    do_op("mult_flushmid", 3'd0, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FC18, 1'b0, 1'b1);

    // Random mult/div against the reference model.
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 300)) : $urandom;
      if (ra == 32'h8000_0000) ra = 32'h7FFF_FFFF;
      r = ref_op(ro, ra, rb, {m_hi, m_lo});
      do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, r[63:32], r[31:0], i[0], i[1]);
    end

    // Reset in the middle of a divide aborts it without a HI/LO write.
    mt_op("pre_rst_hi", 3'd4, 32'hAAAA_5555);
    mt_op("pre_rst_lo", 3'd5, 32'h5555_AAAA);
    start = 1'b1; op = 3'd2; a = 32'd50; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    d_use_xalu = 1'b1;
    #1;
    check("abort_stall_idle", 32'(stall), 32'd0);
    start = 1'b1; op = 3'd1;
    #1;
    check("abort_stall_launch", 32'(stall), 32'd1);
    start = 1'b0; d_use_xalu = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b1;
    do_op("post_rst_mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
